// File: rtl/img_pkg.sv
// Shared types and constants for the frame image-processing blocks.
package img_pkg;

    // Scanner control states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 3x3 Sobel kernels, 4-bit signed coefficients, row-major, tap 0 (top-left) in the LSBs.
    // Sobel-X rows: [-1 0 1] [-2 0 2] [-1 0 1]
    localparam logic [35:0] SOBEL_X = 36'h10F20E10F;
    // Sobel-Y rows: [-1 -2 -1] [0 0 0] [1 2 1]
    localparam logic [35:0] SOBEL_Y = 36'h121000FEF;

    // Accumulator width that can hold the full window sum without overflow
    function automatic int acc_bits(input int pxl_bits, input int coef_bits, input int taps);
        return pxl_bits + coef_bits + $clog2(taps);
    endfunction

endpackage

// File: rtl/win_mac.sv
// Combinational window x kernel multiply-accumulate with saturation to the pixel range.
module win_mac
    import img_pkg::*;
#(
    parameter int WIN_WD    = 3,
    parameter int WIN_HT    = 3,
    parameter int PXL_BITS  = 12,
    parameter int COEF_BITS = 4,
    parameter logic [WIN_HT*WIN_WD*COEF_BITS-1:0] KERNEL = SOBEL_X
) (
    input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0] win,
    output logic [PXL_BITS-1:0]               pxl
);

    localparam int TAPS  = WIN_WD * WIN_HT;
    localparam int ACC_W = acc_bits(PXL_BITS, COEF_BITS, TAPS);

    // Saturation bounds expressed at accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-PXL_BITS+1){1'b0}}, {(PXL_BITS-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-PXL_BITS+1){1'b1}}, {(PXL_BITS-1){1'b0}}};

    logic signed [ACC_W-1:0] prod [TAPS];
    logic signed [ACC_W-1:0] acc;

    // One signed product per tap, both operands sign-extended to accumulator width
    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        logic signed [PXL_BITS-1:0]  tap_pxl;
        logic signed [COEF_BITS-1:0] tap_coef;
        assign tap_pxl  = win[k*PXL_BITS +: PXL_BITS];
        assign tap_coef = KERNEL[k*COEF_BITS +: COEF_BITS];
        assign prod[k]  = ACC_W'(tap_pxl) * ACC_W'(tap_coef);
    end

    // Sum all tap products
    always_comb begin
        acc = '0;
        for (int k = 0; k < TAPS; k++) begin
            acc = acc + prod[k];
        end
    end

    // Clamp the sum into the signed pixel range
    always_comb begin
        pxl = '0;
        if (acc > SAT_MAX) begin
            pxl = {1'b0, {(PXL_BITS-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            pxl = {1'b1, {(PXL_BITS-1){1'b0}}};
        end else begin
            pxl = acc[PXL_BITS-1:0];
        end
    end

endmodule

// File: rtl/frame_conv_scanner.sv
// Raster-scans a source frame one window per cycle, convolves each window with a fixed
// kernel and writes the saturated result to a destination frame, two cycles later.
module frame_conv_scanner
    import img_pkg::*;
#(
    parameter int IMG_WD     = 8,
    parameter int IMG_HT     = 8,
    parameter int COORD_BITS = 4,
    parameter int WIN_WD     = 3,
    parameter int WIN_HT     = 3,
    parameter int PXL_BITS   = 12,
    parameter int COEF_BITS  = 4,
    parameter logic [WIN_HT*WIN_WD*COEF_BITS-1:0] KERNEL = SOBEL_X
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               pause,
    output logic                               busy,
    output logic                               done,
    output logic                               rd_en,
    output logic [COORD_BITS-1:0]              rd_x,
    output logic [COORD_BITS-1:0]              rd_y,
    input  logic [WIN_HT*WIN_WD*PXL_BITS-1:0]  rd_data_flat,
    output logic                               wr_en,
    output logic [COORD_BITS-1:0]              wr_x,
    output logic [COORD_BITS-1:0]              wr_y,
    output logic [PXL_BITS-1:0]                wr_data_pxl
);

    localparam int WIN_BITS = WIN_HT * WIN_WD * PXL_BITS;
    localparam logic [COORD_BITS-1:0] X_LAST = COORD_BITS'(IMG_WD - 1);
    localparam logic [COORD_BITS-1:0] Y_LAST = COORD_BITS'(IMG_HT - 1);

    state_t                  state_r;
    state_t                  state_nxt;
    logic [COORD_BITS-1:0]   x_r;
    logic [COORD_BITS-1:0]   y_r;
    logic                    last_read;

    logic                    s1_valid_r;
    logic [WIN_BITS-1:0]     s1_win_r;
    logic [COORD_BITS-1:0]   s1_x_r;
    logic [COORD_BITS-1:0]   s1_y_r;
    logic [PXL_BITS-1:0]     mac_pxl;

    assign rd_x      = x_r;
    assign rd_y      = y_r;
    assign last_read = rd_en && (x_r == X_LAST) && (y_r == Y_LAST);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // FSM next state and status / read-enable decode
    always_comb begin
        state_nxt = state_r;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            SCAN: begin
                busy  = 1'b1;
                rd_en = !pause;
                if (last_read) begin
                    state_nxt = DRAIN;
                end else begin
                    state_nxt = SCAN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                // Stage 2 is loaded from stage 1 on this edge, so stage 1 empty means
                // the current cycle carries the final write
                if (!s1_valid_r) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRAIN;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Raster coordinate counters; advance only on cycles that issue a read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_r <= '0;
            y_r <= '0;
        end else if ((state_r == IDLE) && start) begin
            x_r <= '0;
            y_r <= '0;
        end else if (rd_en) begin
            if (x_r == X_LAST) begin
                x_r <= '0;
                if (y_r == Y_LAST) begin
                    y_r <= '0;
                end else begin
                    y_r <= y_r + COORD_BITS'(1);
                end
            end else begin
                x_r <= x_r + COORD_BITS'(1);
            end
        end
    end

    // Stage 1: capture the window and its centre coordinates for each issued read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_win_r   <= '0;
            s1_x_r     <= '0;
            s1_y_r     <= '0;
        end else begin
            s1_valid_r <= rd_en;
            if (rd_en) begin
                s1_win_r <= rd_data_flat;
                s1_x_r   <= x_r;
                s1_y_r   <= y_r;
            end
        end
    end

    win_mac #(
        .WIN_WD    (WIN_WD),
        .WIN_HT    (WIN_HT),
        .PXL_BITS  (PXL_BITS),
        .COEF_BITS (COEF_BITS),
        .KERNEL    (KERNEL)
    ) u_mac (
        .win (s1_win_r),
        .pxl (mac_pxl)
    );

    // Stage 2: register the saturated result and drive the destination write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en       <= 1'b0;
            wr_x        <= '0;
            wr_y        <= '0;
            wr_data_pxl <= '0;
        end else begin
            wr_en <= s1_valid_r;
            if (s1_valid_r) begin
                wr_x        <= s1_x_r;
                wr_y        <= s1_y_r;
                wr_data_pxl <= mac_pxl;
            end
        end
    end

endmodule
